tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Runtime-programmable timebase controller for the board's 50 MHz clock. It accepts a divide value and burst length over a valid/ready handshake, then starts, stops and counts a single shared divide counter. It emits a one-cycle `tick` strobe and a toggling `clk_out` square wave. It replaces fixed compile-time division, so display, FSM and debounce logic can retune or single-shot their timing without resynthesis.

## Interface
- `CNT_W`, 25: width of divide counter and `cfg_div`.
- `DEFAULT_DIV`, 25000000: divide value loaded at reset (1 Hz `clk_out` from 50 MHz).
- `DEFAULT_BURST`, 0: burst length loaded at reset (0 = continuous).
- `clk_in` input 1: system clock (50 MHz).
- `rst` input 1: asynchronous, active-high reset.
- `cfg_valid` input 1: config offer.
- `cfg_ready` output 1: config accepted when `cfg_valid & cfg_ready` at a rising edge.
- `cfg_div` input CNT_W: cycles per tick. A value of 0 is stored as 1.
- `cfg_burst` input 8: number of ticks per run. A value of 0 means run until `stop`.
- `start` input 1: begin run (level-sampled, effective only in IDLE).
- `stop` input 1: abort run.
- `tick` output 1: one-cycle strobe, registered.
- `clk_out` output 1: toggles on every tick, registered.
- `busy` output 1: high in RUN (and PAUSED).
- `done` output 1: one-cycle pulse on the final tick of a finite burst.

## Operation
- Reset values:
  - State: IDLE.
  - Counter: 0; burst counter: 0.
  - `div_r` = DEFAULT_DIV, `burst_r` = DEFAULT_BURST.
  - Outputs: `tick`=0, `clk_out`=0, `busy`=0, `done`=0, `cfg_ready`=1.
- States: IDLE, RUN, and PAUSED (PAUSED only with the macro).
- IDLE:
  - `cfg_ready`=1. An accepted config updates `div_r`/`burst_r`.
  - `start & !stop` → RUN. Counter and burst counter are cleared.
  - If config and start arrive in the same cycle, the run uses the newly accepted values.
  - `start & stop` in the same cycle: stay IDLE.
- RUN:
  - `cfg_ready`=0; `cfg_valid` is ignored and no config is lost.
  - Counter increments each cycle.
  - When counter == `div_r`-1: counter ← 0, `tick`←1, `clk_out`←~`clk_out`, burst counter +1.
  - Finite burst: on the tick where burst counter reaches `burst_r`, assert `done`←1 and go to IDLE at that edge.
  - Continuous mode: burst counter saturates at 255 and does not wrap; it is unused.
- `stop` in RUN/PAUSED:
  - → IDLE next edge; counter cleared; `clk_out`←0; `tick`/`done` stay 0.
  - `stop` wins over a coincident final tick, so `done` is not asserted.
- Counter arithmetic: unsigned CNT_W bits. The compare-and-clear happens before any overflow, so no wrap is possible.
- Mid-run `rst`: all state returns to reset values immediately (asynchronous). Config is restored to the defaults.

## Timing
- `start` sampled at edge E0: `busy`=1 after E0. First `tick` is high for the cycle following edge E0+`div_r`; later ticks follow every `div_r` cycles.
- With `div_r`=1, `tick` is high every cycle from E0+1 and `clk_out` toggles every cycle.
- `clk_out` period = 2·`div_r` cycles, 50% duty.
- Final burst tick at edge Ef: `tick`=1, `done`=1, `busy`=0 in the cycle after Ef. A new `start` is accepted at Ef+1.
- Config latency: 0 cycles. A value accepted at edge E applies from the next run.

## Configuration
- Macro: `TICK_SCHED_PAUSE_EN`.
- Defined:
  - Adds input `pause` (1 bit).
  - RUN with `pause`=1 → PAUSED. Counter, burst counter and `clk_out` are frozen and `tick` is 0.
  - PAUSED with `pause`=0 → RUN, resuming the count where it stopped.
  - `stop` overrides `pause`. `cfg_ready`=0 in PAUSED.
- Undefined: no `pause` port and no PAUSED state. RUN runs until burst end or `stop`.

## Test plan
- Reset then release with no stimulus: `cfg_ready`=1, `busy`=0, `tick`/`clk_out`/`done`=0. Start with defaults overridden to `CNT_W`=4, `DEFAULT_DIV`=4: ticks every 4 cycles, `clk_out` period 8.
- Config `cfg_div`=3, `cfg_burst`=2, then `start` at E0: ticks at E0+3 and E0+6. `done` high with the second tick; `busy` low after E0+6; exactly 2 `clk_out` toggles.
- `cfg_div`=0, burst 0, `start`: `tick` high every cycle. `stop` after 5 cycles: IDLE next edge, `clk_out`=0, no `done`.
- `cfg_valid` asserted in RUN with `cfg_div`=7: `cfg_ready`=0 and the period stays unchanged. Once IDLE, the same `cfg_valid` is accepted.
- `stop` coincident with the final burst tick (`div`=2, `burst`=1, stop at E0+2): `done`=0, `tick`=0, state IDLE. `start`+`stop` together in IDLE: stays IDLE.
- Assert `rst` mid-run at counter=2, div=5: outputs are 0 immediately. After release, `div_r` is back to DEFAULT_DIV.
- With `TICK_SCHED_PAUSE_EN`, `pause` for 10 cycles: no tick, `clk_out` frozen. The next tick arrives 10 cycles later than unpaused.

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler: runtime-programmable timebase producing a tick strobe and a square wave
//
// Ports:
//   clk_in     system clock (50 MHz)
//   rst        asynchronous active-high reset
//   cfg_valid  configuration offer; accepted while cfg_ready is high
//   cfg_ready  high in IDLE only
//   cfg_div    cycles per tick (0 is stored as 1)
//   cfg_burst  ticks per run (0 = run until stop)
//   start      begin a run (sampled in IDLE)
//   stop       abort a run
//   pause      freeze the run (present only with TICK_SCHED_PAUSE_EN)
//   tick       one-cycle registered strobe
//   clk_out    registered square wave, toggles on every tick
//   busy       high while a run is active
//   done       one-cycle pulse on the final tick of a finite burst
//
// Optional feature: define TICK_SCHED_PAUSE_EN to add the pause input and PAUSED state.
module tick_scheduler #(
    parameter int unsigned CNT_W         = 25,
    parameter int unsigned DEFAULT_DIV   = 25000000,
    parameter int unsigned DEFAULT_BURST = 0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [7:0]       cfg_burst,
    input  logic             start,
    input  logic             stop,
`ifdef TICK_SCHED_PAUSE_EN
    input  logic             pause,
`endif
    output logic             tick,
    output logic             clk_out,
    output logic             busy,
    output logic             done
);
`ifdef TICK_SCHED_PAUSE_EN
    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
`else
    typedef enum logic {IDLE, RUN} state_t;
`endif

    localparam logic [CNT_W-1:0] RST_DIV   = (DEFAULT_DIV == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_DIV);
    localparam logic [7:0]       RST_BURST = 8'(DEFAULT_BURST);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [7:0]       bcnt_q, bcnt_d;
    logic [7:0]       burst_q, burst_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;
    logic             done_q, done_d;
    logic             wrap;
    logic             last;

    // div_q is never 0, so div_q-1 cannot underflow and the counter clears before it overflows
    assign wrap = cnt_q == div_q - CNT_W'(1);
    assign last = burst_q != 8'd0 && bcnt_q + 8'd1 == burst_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bcnt_d    = bcnt_q;
        burst_d   = burst_q;
        tick_d    = 1'b0;
        clk_out_d = clk_out_q;
        done_d    = 1'b0;
        if (state_q == IDLE) begin
            if (cfg_valid) begin
                div_d   = cfg_div == '0 ? CNT_W'(1) : cfg_div;
                burst_d = cfg_burst;
            end
            if (start && !stop) begin
                state_d = RUN;
                cnt_d   = '0;
                bcnt_d  = '0;
            end
        end else if (stop) begin
            state_d   = IDLE;
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end
`ifdef TICK_SCHED_PAUSE_EN
        else if (pause) begin
            state_d = PAUSED;
        end
`endif
        else begin
            // a paused run resumes counting on the same edge it leaves PAUSED
            state_d = RUN;
            if (wrap) begin
                cnt_d     = '0;
                tick_d    = 1'b1;
                clk_out_d = ~clk_out_q;
                bcnt_d    = bcnt_q == 8'hff ? bcnt_q : bcnt_q + 8'd1;
                if (last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= RST_DIV;
            bcnt_q    <= '0;
            burst_q   <= RST_BURST;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bcnt_q    <= bcnt_d;
            burst_q   <= burst_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
            done_q    <= done_d;
        end
    end

    assign cfg_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign tick      = tick_q;
    assign clk_out   = clk_out_q;
    assign done      = done_q;
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed-vector bench for tick_scheduler
module tb_tick_scheduler;
    localparam int CNT_W = 4;

    logic             clk_in = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic [7:0]       cfg_burst = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
`ifdef TICK_SCHED_PAUSE_EN
    logic             pause = 1'b0;
`endif
    logic             cfg_ready, tick, clk_out, busy, done;
    int               n_vec = 0;
    int               n_err = 0;
    int               toggles;
    logic             prev_clk;

    always #5 clk_in = ~clk_in;

    tick_scheduler #(.CNT_W(CNT_W), .DEFAULT_DIV(4), .DEFAULT_BURST(0)) dut (
        .clk_in(clk_in),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div(cfg_div),
        .cfg_burst(cfg_burst),
        .start(start),
        .stop(stop),
`ifdef TICK_SCHED_PAUSE_EN
        .pause(pause),
`endif
        .tick(tick),
        .clk_out(clk_out),
        .busy(busy),
        .done(done)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cfg(input logic [CNT_W-1:0] d, input logic [7:0] b);
        cfg_valid = 1'b1;
        cfg_div   = d;
        cfg_burst = b;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset {rdy,busy,tick,clk,done}", {3'b0, cfg_ready, busy, tick, clk_out, done}, 8'b10000);

        go();
        chk("def busy", {7'b0, busy}, 8'd1);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("def tick k%0d", k), {7'b0, tick}, {7'b0, k % 4 == 0});
            if (k % 4 == 0)
                chk($sformatf("def clk k%0d", k), {7'b0, clk_out}, 8'((k / 4) % 2));
        end
        halt();
        chk("def stop {busy,tick,clk}", {5'b0, busy, tick, clk_out}, 8'b000);

        cfg(3, 2);
        go();
        toggles  = 0;
        prev_clk = clk_out;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("burst {tick,done,busy} k%0d", k), {5'b0, tick, done, busy},
                {5'b0, k == 3 || k == 6, k == 6, k < 6});
            if (clk_out != prev_clk) toggles++;
            prev_clk = clk_out;
        end
        chk("burst toggles", 8'(toggles), 8'd2);
        chk("burst rdy", {7'b0, cfg_ready}, 8'd1);

        cfg_valid = 1'b1;
        cfg_div   = 0;
        cfg_burst = 0;
        start     = 1'b1;
        step();
        cfg_valid = 1'b0;
        start     = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("div0 {tick,clk} k%0d", k), {6'b0, tick, clk_out}, {6'b0, 1'b1, k[0]});
        end
        halt();
        chk("div0 stop {tick,clk,busy,done}", {4'b0, tick, clk_out, busy, done}, 8'b0000);

        cfg(3, 0);
        go();
        cfg_valid = 1'b1;
        cfg_div   = 7;
        cfg_burst = 0;
        chk("run rdy", {7'b0, cfg_ready}, 8'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("run cfg tick k%0d", k), {7'b0, tick}, {7'b0, k % 3 == 0});
        end
        halt();
        chk("idle rdy", {7'b0, cfg_ready}, 8'd1);
        step();
        cfg_valid = 1'b0;
        go();
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("div7 tick k%0d", k), {7'b0, tick}, {7'b0, k == 7});
        end
        halt();

        cfg(2, 1);
        go();
        step();
        chk("coinc pre tick", {7'b0, tick}, 8'd0);
        halt();
        chk("coinc {tick,done,busy,clk}", {4'b0, tick, done, busy, clk_out}, 8'b0000);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("start+stop busy", {7'b0, busy}, 8'd0);

        cfg(5, 0);
        go();
        step();
        step();
        chk("pre rst busy", {7'b0, busy}, 8'd1);
        rst = 1'b1;
        #1;
        chk("async rst {tick,clk,busy,done,rdy}", {3'b0, tick, clk_out, busy, done, cfg_ready}, 8'b00001);
        step();
        rst = 1'b0;
        go();
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("post rst tick k%0d", k), {7'b0, tick}, {7'b0, k % 4 == 0});
        end
        halt();

`ifdef TICK_SCHED_PAUSE_EN
        go();
        step();
        step();
        pause = 1'b1;
        for (int k = 3; k <= 12; k++) begin
            step();
            chk($sformatf("paused {tick,clk,busy} k%0d", k), {5'b0, tick, clk_out, busy}, 8'b001);
        end
        pause = 1'b0;
        for (int k = 13; k <= 16; k++) begin
            step();
            chk($sformatf("resume tick k%0d", k), {7'b0, tick}, {7'b0, k == 14});
        end
        halt();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
